// File: rtl/jtag_dr_bridge.sv
// jtag_dr_bridge: oversampled JTAGG ER1/ER2 data register with capture readback, length check and valid/ready update port
module jtag_dr_bridge #(
  parameter int DR_W        = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtck,
  input  logic              jtdi,
  input  logic              jshift,
  input  logic              jupdate,
  input  logic              jce1,
  input  logic              jce2,
  input  logic              jrstn,
  output logic              jtdo1,
  output logic              jtdo2,
  input  logic [2*DR_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              rd_sel,
  output logic [DR_W-1:0]   upd_data,
  output logic              upd_sel,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic              len_err,
  output logic              overrun,
  input  logic              clr_flags
);
  localparam int CW = $clog2(DR_W + 2);
  logic [SYNC_STAGES-1:0][6:0] sync_q, sync_d;
  logic s_tck, s_tdi, s_shift, s_update, s_ce1, s_ce2, s_rstn;
  logic tck_q, tck_d;
  logic st_shift_q, st_shift_d, st_ce_q, st_ce_d, st_sel_q, st_sel_d;
  logic [DR_W-1:0] sr_q, sr_d, upd_data_q, upd_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_ack_q, rd_ack_d, rd_sel_q, rd_sel_d;
  logic upd_sel_q, upd_sel_d, upd_valid_q, upd_valid_d;
  logic len_err_q, len_err_d, overrun_q, overrun_d, tdo_q, tdo_d;
  logic tck_rise, cap, shf, upd, len_bad, busy, load;
  assign {s_tck, s_tdi, s_shift, s_update, s_ce1, s_ce2, s_rstn} = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], {jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn}};
    tck_d       = s_tck;
    tck_rise    = s_tck & ~tck_q;
    cap         = tck_rise & st_ce_q & ~st_shift_q;
    shf         = tck_rise & st_shift_q;
    upd         = tck_rise & s_update;
    len_bad     = cnt_q != CW'(DR_W);
    busy        = upd_valid_q & ~upd_ready;
    load        = upd & ~len_bad & ~busy;
    sr_d        = ~s_rstn ? '0 :
                  cap ? (st_sel_q ? rd_data[2*DR_W-1:DR_W] : rd_data[DR_W-1:0]) :
                  shf ? {s_tdi, sr_q[DR_W-1:1]} : sr_q;
    cnt_d       = ~s_rstn ? '0 : cap ? '0 :
                  (shf && cnt_q != CW'(DR_W + 1)) ? cnt_q + 1'b1 : cnt_q;
    st_shift_d  = ~s_rstn ? 1'b0 : tck_rise ? s_shift : st_shift_q;
    st_ce_d     = ~s_rstn ? 1'b0 : tck_rise ? (s_ce1 | s_ce2) : st_ce_q;
    st_sel_d    = ~s_rstn ? 1'b0 : (tck_rise & (s_ce1 | s_ce2)) ? s_ce2 : st_sel_q;
    rd_ack_d    = cap;
    rd_sel_d    = cap ? st_sel_q : rd_sel_q;
    upd_data_d  = load ? sr_q : upd_data_q;
    upd_sel_d   = load ? st_sel_q : upd_sel_q;
    upd_valid_d = load | busy;
    len_err_d   = (upd & len_bad) | (len_err_q & ~clr_flags);
    overrun_d   = (upd & ~len_bad & busy) | (overrun_q & ~clr_flags);
    tdo_d       = sr_d[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      tck_q       <= 1'b0;
      st_shift_q  <= 1'b0;
      st_ce_q     <= 1'b0;
      st_sel_q    <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      rd_ack_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      upd_data_q  <= '0;
      upd_sel_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      tdo_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      tck_q       <= tck_d;
      st_shift_q  <= st_shift_d;
      st_ce_q     <= st_ce_d;
      st_sel_q    <= st_sel_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rd_ack_q    <= rd_ack_d;
      rd_sel_q    <= rd_sel_d;
      upd_data_q  <= upd_data_d;
      upd_sel_q   <= upd_sel_d;
      upd_valid_q <= upd_valid_d;
      len_err_q   <= len_err_d;
      overrun_q   <= overrun_d;
      tdo_q       <= tdo_d;
    end
  end
  assign jtdo1     = tdo_q;
  assign jtdo2     = tdo_q;
  assign rd_ack    = rd_ack_q;
  assign rd_sel    = rd_sel_q;
  assign upd_data  = upd_data_q;
  assign upd_sel   = upd_sel_q;
  assign upd_valid = upd_valid_q;
  assign len_err   = len_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_jtag_dr_bridge.sv
// tb_jtag_dr_bridge: scoreboard bench driving slow JTAGG-style transactions into jtag_dr_bridge
module tb_jtag_dr_bridge;
  localparam int DR_W = 32;
  localparam int SS = 3;
  localparam int L = 8;
  logic clk = 1'b0;
  logic rst, jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn;
  logic jtdo1, jtdo2, rd_ack, rd_sel, upd_sel, upd_valid, upd_ready, len_err, overrun, clr_flags;
  logic [2*DR_W-1:0] rd_data;
  logic [DR_W-1:0] upd_data;
  int checks = 0;
  int errors = 0;
  logic rd_q[$];
  logic [DR_W:0] upd_q[$];
  jtag_dr_bridge #(.DR_W(DR_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .jtck(jtck), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
    .jce1(jce1), .jce2(jce2), .jrstn(jrstn), .jtdo1(jtdo1), .jtdo2(jtdo2),
    .rd_data(rd_data), .rd_ack(rd_ack), .rd_sel(rd_sel), .upd_data(upd_data),
    .upd_sel(upd_sel), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .len_err(len_err), .overrun(overrun), .clr_flags(clr_flags)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_ack) begin
        check("rd_ack_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) check("rd_sel", rd_sel, rd_q.pop_front());
      end
      if (upd_valid && upd_ready) begin
        check("upd_expected", upd_q.size() != 0, 1);
        if (upd_q.size() != 0) check("upd_word", {upd_sel, upd_data}, upd_q.pop_front());
      end
    end
  end
  task automatic check_reset_outs();
    check("rst_jtdo1", jtdo1, 0);
    check("rst_jtdo2", jtdo2, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_sel", rd_sel, 0);
    check("rst_upd_data", upd_data, 0);
    check("rst_upd_sel", upd_sel, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_len_err", len_err, 0);
    check("rst_overrun", overrun, 0);
  endtask
  task automatic tick(logic ce, logic sel, logic sh, logic up, logic di);
    jce1 = ce & ~sel;
    jce2 = ce & sel;
    jshift = sh;
    jupdate = up;
    jtdi = di;
    jtck = 1'b0;
    repeat (L) @(posedge clk);
    #1 jtck = 1'b1;
    repeat (L) @(posedge clk);
    #1;
  endtask
  task automatic txn(logic sel, logic [31:0] w, int n, logic load, logic chk_tdo, int abort);
    logic [31:0] t1 = '0;
    logic [31:0] t2 = '0;
    logic [31:0] cap = sel ? rd_data[63:32] : rd_data[31:0];
    tick(1, sel, 0, 0, 0);
    rd_q.push_back(sel);
    tick(1, sel, 1, 0, 0);
    for (int i = 0; i < n; i++) begin
      if (abort > 0 && i == abort) return;
      if (i < DR_W) begin
        t1[i] = jtdo1;
        t2[i] = jtdo2;
      end
      tick(i != n - 1, sel, i != n - 1, 0, w[i % 32]);
    end
    if (load) upd_q.push_back({sel, w});
    tick(0, sel, 0, 1, 0);
    tick(0, sel, 0, 0, 0);
    if (chk_tdo) begin
      check("tdo1_word", t1, cap);
      check("tdo2_word", t2, cap);
    end
  endtask
  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
  endtask
  initial begin
    logic [31:0] c;
    rst = 1'b1;
    {jtck, jtdi, jshift, jupdate, jce1, jce2} = '0;
    jrstn = 1'b1;
    upd_ready = 1'b1;
    clr_flags = 1'b0;
    rd_data = {32'h0F1E2D3C, 32'hCAFEBABE};
    repeat (5) @(posedge clk);
    #1 check_reset_outs();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    txn(0, 32'h12345678, 32, 1, 1, 0);
    txn(1, 32'hA5A5A5A5, 32, 1, 1, 0);
    check("no_len_err", len_err, 0);
    txn(0, 32'h0, 31, 0, 0, 0);
    check("len31_err", len_err, 1);
    check("len31_valid", upd_valid, 0);
    pulse_clr();
    check("len31_clr", len_err, 0);
    txn(1, 32'hFFFF0000, 40, 0, 0, 0);
    check("len40_err", len_err, 1);
    check("len40_valid", upd_valid, 0);
    pulse_clr();
    check("len40_clr", len_err, 0);
    upd_ready = 1'b0;
    txn(0, 32'h1, 32, 1, 0, 0);
    txn(0, 32'h2, 32, 0, 0, 0);
    check("ovr_valid", upd_valid, 1);
    check("ovr_data", upd_data, 1);
    check("ovr_flag", overrun, 1);
    upd_ready = 1'b1;
    @(posedge clk);
    #1 check("ovr_drain", upd_valid, 0);
    pulse_clr();
    check("ovr_clr", overrun, 0);
    c = rd_data[31:0];
    txn(0, 32'hDEADBEEF, 32, 0, 0, 11);
    check("tdo_pre_jrstn", jtdo1, c[11]);
    jrstn = 1'b0;
    repeat (SS + 3) @(posedge clk);
    #1 check("tdo_jrstn", jtdo1, 0);
    jrstn = 1'b1;
    repeat (SS + 3) @(posedge clk);
    #1;
    txn(0, 32'hDEADBEEF, 32, 1, 1, 0);
    check("jrstn_len_err", len_err, 0);
    upd_ready = 1'b0;
    txn(1, 32'h55, 32, 0, 0, 0);
    check("held_valid", upd_valid, 1);
    check("held_data", upd_data, 32'h55);
    txn(0, 32'h3C3C3C3C, 32, 0, 0, 5);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    {jtck, jtdi, jshift, jupdate, jce1, jce2} = '0;
    check_reset_outs();
    upd_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    txn(0, 32'h3C3C3C3C, 32, 1, 1, 0);
    check("post_rst_len_err", len_err, 0);
    repeat (20) @(posedge clk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("upd_q_drained", upd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_dr_bridge.md
# jtag_dr_bridge

Parametrised JTAG user-data-register bridge between the ECP5 JTAGG primitive (ER1/IR 0x32, ER2/IR 0x38) and the SoC debug-register interface, running entirely in the fabric clock domain. It oversamples TCK, shifts a DR_W-bit data register, and supports capture-DR readback on TDO, which the current DR logic lacks. It also checks shift length and delivers completed words through a valid/ready handshake with overrun detection. It replaces the inline DR logic in the top level; the SoC consumes `upd_*` and supplies `rd_data`.

## Interface
- `DR_W`, 32: data register width in bits (≥2).
- `SYNC_STAGES`, 3: synchroniser depth for all JTAG-side inputs (≥2).
- `clk` in 1: fabric clock (clk48m in the top level).
- `rst` in 1: reset, synchronous, active-high.
- `jtck`, `jtdi`, `jshift`, `jupdate`, `jce1`, `jce2`, `jrstn` in 1 each: raw JTAGG outputs, asynchronous to `clk`.
- `jtdo1`, `jtdo2` out 1: TDO to JTAGG for ER1 and ER2.
- `rd_data` in 2*DR_W: capture words; [DR_W-1:0] for ER1, [2*DR_W-1:DR_W] for ER2.
- `rd_ack` out 1: one-cycle pulse when `rd_data` is captured.
- `rd_sel` out 1: channel captured at the `rd_ack` pulse (0=ER1, 1=ER2).
- `upd_data` out DR_W: completed shifted word.
- `upd_sel` out 1: channel of `upd_data`.
- `upd_valid` out 1: word available.
- `upd_ready` in 1: consumer accepts.
- `len_err` out 1: sticky; an update arrived with a bit count ≠ DR_W.
- `overrun` out 1: sticky; an update arrived while the holding word was pending.
- `clr_flags` in 1: clears `len_err` and `overrun`.

## Operation
- Each JTAG input passes through its own SYNC_STAGES flop chain. `s_*` denotes the last stage. `tck_q` is `s_tck` delayed one clock. An edge cycle is one where `s_tck & ~tck_q`.
- Edge-latched state, updated only on edge cycles: `st_shift <= s_shift`, `st_ce <= s_ce1|s_ce2`, and `st_sel <= s_ce2` when `s_ce1|s_ce2`.
- Actions on an edge cycle, all evaluated from `st_*` values before the update:
  - Capture, when `st_ce & ~st_shift`: `sr <= rd_data` slice for `st_sel`, `cnt <= 0`. Pulse `rd_ack` next cycle with `rd_sel = st_sel`.
  - Shift, when `st_shift`: `sr <= {s_tdi, sr[DR_W-1:1]}`. `cnt` increments and saturates at DR_W+1.
  - Update, when `s_update`:
    - If `cnt != DR_W`: set `len_err` and drop the word.
    - Else if `upd_valid & ~upd_ready`: set `overrun` and drop the new word; the held word is unchanged.
    - Else: `upd_data <= sr`, `upd_sel <= st_sel`, `upd_valid <= 1`.
  - Capture and update are mutually exclusive by TAP state. Shift and update in the same edge cycle cannot occur.
- Handshake:
  - `upd_valid` clears in the cycle after `upd_valid & upd_ready`.
  - A new word arriving in the same cycle as acceptance is loaded, and `upd_valid` stays 1.
  - `upd_data`/`upd_sel` are stable while `upd_valid` is high.
- TDO: `jtdo1 = jtdo2 = sr[0]`, registered.
- `clr_flags` clears both stickies. A set event in the same cycle wins.
- `s_jrstn == 0` clears `sr`, `cnt`, `st_*`. It does not affect `upd_*`, `rd_*` or the stickies.

## Timing
- Reset values: `jtdo1 = jtdo2 = 0`, `rd_ack = 0`, `rd_sel = 0`, `upd_data = 0`, `upd_sel = 0`, `upd_valid = 0`, `len_err = 0`, `overrun = 0`. Internal `sr`, `cnt`, `st_*`, sync chains and `tck_q` all reset to 0.
- Latency from a `jtck` rise to the edge cycle is SYNC_STAGES+1 clocks. Registered effects (`upd_valid`, `rd_ack`, `sr`, `jtdo*`) appear 1 clock later.
- TCK high and low phases must each be ≥ SYNC_STAGES+2 clk periods. With 48 MHz and the defaults, TCK ≤ 4.8 MHz. Faster TCK is unsupported and unchecked.
- `jtdi`, `jshift`, `jupdate` and `jce*` must be stable ≥ 1 clk before the synchronised TCK rise. Equal sync depth guarantees this for JTAGG timing.
- `rst` asserted mid-shift discards all partial state. The first valid transaction after release must start with Capture-DR.

## Test plan
- ER1 transaction, DR_W=32: capture with `rd_data[31:0]=0xCAFEBABE`, then 32 shifts of 0x12345678 LSB-first, then update -> `rd_ack` pulse with `rd_sel=0`; `jtdo1` sequence yields 0xCAFEBABE; `upd_valid=1`, `upd_data=0x12345678`, `upd_sel=0`.
- ER2 transaction with 0xA5A5A5A5 -> `upd_sel=1`, `upd_data=0xA5A5A5A5`; capture uses `rd_data[63:32]`.
- 31-bit shift then update, and separately 40-bit shift then update -> `upd_valid` stays 0 and `len_err=1`; `clr_flags` pulse -> `len_err=0`.
- Hold `upd_ready=0` through two complete transactions 0x1 then 0x2 -> `upd_data=0x1` and `overrun=1`. Raise `upd_ready` -> `upd_valid` drops the next cycle.
- Pulse `jrstn` low mid-shift, then run a full transaction with 0xDEADBEEF -> `upd_data=0xDEADBEEF` and no `len_err`.
- Assert `rst` mid-shift for 1 clock -> all outputs return to reset values; a following full transaction completes normally.
